// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge/auto-repeat conditions three push buttons
//   clk         pixel clock, the only clock
//   reset       asynchronous active-high reset
//   but_raw     raw pins, bit0=but1 .. bit2=but3 (polarity set by ACTIVE_LOW)
//   but_level   debounced state, 1 = pressed
//   but_press   one-cycle pulse on debounced press and on each auto-repeat
//   but_release one-cycle pulse on debounced release
module button_conditioner #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 315000,
  parameter int REPEAT_DELAY    = 15750000,
  parameter int REPEAT_PERIOD   = 3150000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] but_raw,
  output logic [2:0] but_level,
  output logic [2:0] but_press,
  output logic [2:0] but_release
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {OFF, DELAY, RUN} state_t;
  logic [2:0] w_n, r_s1, r_s2, w_level, w_rise, w_fall, w_rep;
  logic [2:0] r_press, r_release;
  assign w_n         = ACTIVE_LOW != 0 ? ~but_raw : but_raw;
  assign but_level   = w_level;
  assign but_press   = r_press;
  assign but_release = r_release;
  // Pulses are registered from the same condition that updates the level,
  // so they rise on the very edge the level changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_s1      <= w_n;
      r_s2      <= r_s1;
      r_press   <= w_rise | w_rep;
      r_release <= w_fall;
    end
  end
  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt, w_rcnt_nx;
    state_t        r_state, w_state_nx;
    logic          r_lvl, w_chg, w_done, w_rp;
    assign w_chg     = r_s2[g] != r_lvl;
    assign w_done    = w_chg && r_dcnt == DC_LAST;
    assign w_rise[g] = w_done && r_s2[g];
    assign w_fall[g] = w_done && !r_s2[g];
    assign w_rep[g]  = w_rp;
    assign w_level[g] = r_lvl;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_dcnt  <= '0;
        r_lvl   <= 1'b0;
        r_rcnt  <= '0;
        r_state <= OFF;
      end else begin
        r_dcnt  <= (!w_chg || w_done) ? '0 : r_dcnt + 1'b1;
        r_lvl   <= w_done ? r_s2[g] : r_lvl;
        r_rcnt  <= w_rcnt_nx;
        r_state <= w_state_nx;
      end
    end
    // Release wins over any repeat due in the same cycle.
    always_comb begin
      w_state_nx = r_state;
      w_rcnt_nx  = r_rcnt + 1'b1;
      w_rp       = 1'b0;
      if (w_fall[g]) begin
        w_state_nx = OFF;
        w_rcnt_nx  = '0;
      end else if (r_state == OFF) begin
        w_rcnt_nx  = '0;
        w_state_nx = (w_rise[g] && REPEAT_DELAY != 0) ? DELAY : OFF;
      end else if (r_state == DELAY && r_rcnt == RD_LAST) begin
        w_state_nx = RUN;
        w_rcnt_nx  = '0;
        w_rp       = 1'b1;
      end else if (r_state == RUN && r_rcnt == RP_LAST) begin
        w_rcnt_nx  = '0;
        w_rp       = 1'b1;
      end
    end
  end
endmodule
